// File: rtl/combo_sweep_pkg.sv
// Shared types and sizing helpers for the combinational-unit sweep sequencer.
package combo_sweep_pkg;

  localparam int N_IN_DEF = 5;
  localparam int NVEC_DEF = 2 ** N_IN_DEF;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Settle counter needs at least one bit even when SETTLE_CYC is 0.
  function automatic int settle_w(input int settle_cyc);
    int w;
    w = $clog2(settle_cyc + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/combo_sweep_ctrl_if.sv
// Host/unit-facing bundle of the sweep sequencer; master = sequencer, slave = host + unit.
interface combo_sweep_ctrl_if #(
  parameter int N_IN = combo_sweep_pkg::N_IN_DEF
);
  localparam int NVEC = 2 ** N_IN;

  logic            start;
  logic            abort;
  logic [NVEC-1:0] expected;
  logic [N_IN-1:0] vec;
  logic            z;
  logic            busy;
  logic            done;
  logic            pass;
  logic [NVEC-1:0] tt;
  logic [N_IN:0]   err_cnt;
  logic [N_IN-1:0] first_err_idx;
  logic            first_err_vld;

  modport master (
    input  start, abort, expected, z,
    output vec, busy, done, pass, tt, err_cnt, first_err_idx, first_err_vld
  );

  modport slave (
    output start, abort, expected, z,
    input  vec, busy, done, pass, tt, err_cnt, first_err_idx, first_err_vld
  );

endinterface

// File: rtl/combo_sweep_chk.sv
// Truth-table capture and golden compare: records z per vector, counts mismatches,
// remembers the lowest failing index. o_miss flags a mismatch on the current sample.
module combo_sweep_chk
  import combo_sweep_pkg::*;
#(
  parameter int N_IN = N_IN_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_sample_en,
  input  logic [N_IN-1:0]      i_idx,
  input  logic                 i_z,
  input  logic                 i_exp_bit,
  output logic [2**N_IN-1:0]   o_tt,
  output logic [N_IN:0]        o_err_cnt,
  output logic [N_IN-1:0]      o_first_err_idx,
  output logic                 o_first_err_vld,
  output logic                 o_miss
);

  localparam logic [N_IN:0] ERR_ONE = 1;

  logic [2**N_IN-1:0] r_tt;
  logic [N_IN:0]      r_err_cnt;
  logic [N_IN-1:0]    r_first_err_idx;
  logic               r_first_err_vld;
  logic               w_miss;

  assign w_miss = i_sample_en && (i_z != i_exp_bit);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_tt            <= '0;
      r_err_cnt       <= '0;
      r_first_err_idx <= '0;
      r_first_err_vld <= 1'b0;
    end else if (i_sample_en) begin
      r_tt[i_idx] <= i_z;
      if (w_miss) begin
        r_err_cnt <= r_err_cnt + ERR_ONE;
        if (!r_first_err_vld) begin
          r_first_err_idx <= i_idx;
          r_first_err_vld <= 1'b1;
        end
      end
    end
  end

  assign o_tt            = r_tt;
  assign o_err_cnt       = r_err_cnt;
  assign o_first_err_idx = r_first_err_idx;
  assign o_first_err_vld = r_first_err_vld;
  assign o_miss          = w_miss;

endmodule

// File: rtl/combo_sweep_ctrl.sv
// Exhaustive sweep sequencer: steps vec through all 2**N_IN codes, holding each
// SETTLE_CYC+1 cycles, then reports the captured truth table against a golden copy.
module combo_sweep_ctrl
  import combo_sweep_pkg::*;
#(
  parameter int N_IN       = N_IN_DEF,
  parameter int SETTLE_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  combo_sweep_ctrl_if.master sweep
);

  localparam int              NVEC        = 2 ** N_IN;
  localparam int              SW          = settle_w(SETTLE_CYC);
  localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE_CYC);
  localparam logic [SW-1:0]   SETTLE_ONE  = 1;
  localparam logic [N_IN-1:0] VEC_LAST    = '1;
  localparam logic [N_IN-1:0] VEC_ONE     = 1;

  state_t          r_state;
  logic [SW-1:0]   r_settle_cnt;
  logic [NVEC-1:0] r_exp_q;
  logic [N_IN-1:0] r_vec;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;

  logic            w_sample;
  logic            w_clr;
  logic            w_miss;
  logic [NVEC-1:0] w_tt;
  logic [N_IN:0]   w_err_cnt;
  logic [N_IN-1:0] w_first_err_idx;
  logic            w_first_err_vld;

  // Abort outranks the sample that would otherwise land on the same edge.
  assign w_sample = (r_state == RUN) && !sweep.abort && (r_settle_cnt == SETTLE_LAST);
  assign w_clr    = (r_state == IDLE) && sweep.start;

  combo_sweep_chk #(.N_IN(N_IN)) u_chk (
    .clk             (clk),
    .rst             (rst),
    .i_clr           (w_clr),
    .i_sample_en     (w_sample),
    .i_idx           (r_vec),
    .i_z             (sweep.z),
    .i_exp_bit       (r_exp_q[r_vec]),
    .o_tt            (w_tt),
    .o_err_cnt       (w_err_cnt),
    .o_first_err_idx (w_first_err_idx),
    .o_first_err_vld (w_first_err_vld),
    .o_miss          (w_miss)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_settle_cnt <= '0;
      r_exp_q      <= '0;
      r_vec        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (sweep.start) begin
            r_state      <= RUN;
            r_exp_q      <= sweep.expected;
            r_vec        <= '0;
            r_settle_cnt <= '0;
            r_busy       <= 1'b1;
            r_pass       <= 1'b0;
          end
        end
        RUN: begin
          if (sweep.abort) begin
            r_state      <= IDLE;
            r_vec        <= '0;
            r_settle_cnt <= '0;
            r_busy       <= 1'b0;
          end else if (r_settle_cnt == SETTLE_LAST) begin
            r_settle_cnt <= '0;
            if (r_vec == VEC_LAST) begin
              r_state <= IDLE;
              r_vec   <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              // Count is registered, so fold in the comparison happening now.
              r_pass  <= (w_err_cnt == '0) && !w_miss;
            end else begin
              r_vec <= r_vec + VEC_ONE;
            end
          end else begin
            r_settle_cnt <= r_settle_cnt + SETTLE_ONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sweep.vec           = r_vec;
  assign sweep.busy          = r_busy;
  assign sweep.done          = r_done;
  assign sweep.pass          = r_pass;
  assign sweep.tt            = w_tt;
  assign sweep.err_cnt       = w_err_cnt;
  assign sweep.first_err_idx = w_first_err_idx;
  assign sweep.first_err_vld = w_first_err_vld;

endmodule
